rr_encoder_4t2: RTL and testbench
=================================

RR_ENCODER_4T2 -- requirements
Module: rr_encoder_4t2

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum number of consecutive cycles one grant is held (legal range 1..8).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port datain  input  4  SHALL carry the request vector; bit i high means requester i requests.
REQ-005 Port release  input  1  SHALL mean the current grantee is finished; it is ignored when no grant is active.
REQ-006 Port gnt_valid  output  1  SHALL mean data_out holds a live grant.
REQ-007 Port data_out  output  2  SHALL carry the registered binary index of the granted requester, directly consumable by the 2-to-4 decoder.
REQ-008 Port hold_cnt  output  3  SHALL report the cycles elapsed in the current grant, starting at 0.

Function
REQ-009 The FSM SHALL have exactly two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-010 Arbitration SHALL be round-robin: search order starts at (last+1) mod 4, where last is the most recently granted index, and wraps 3->0.
REQ-011 IDLE->GRANT SHALL occur on the first edge where datain!=0.
- data_out = first requester found in search order.
- hold_cnt = 0.
- Latency: gnt_valid is high one cycle after the request is sampled.
REQ-012 In GRANT, the grant SHALL end at an edge when any of the following holds:
- release=1;
- datain[data_out]=0;
- hold_cnt==MAX_HOLD-1.
REQ-013 While none of the REQ-012 end conditions holds, GRANT SHALL stay, data_out SHALL stay constant, and hold_cnt SHALL increment by 1.
REQ-014 At a grant end, last SHALL become data_out, and the block SHALL re-arbitrate on that same edge.
- Eligible: datain masked to exclude the ending grantee, unless that grantee is the only requester.
- Some eligible requester: stay in GRANT with the new index, hold_cnt=0, no idle bubble.
- No eligible requester: go to IDLE; gnt_valid=0, data_out keeps its last value, hold_cnt=0.
REQ-015 If the sole requester is still requesting and is not releasing when its hold expires, it SHALL be re-granted with hold_cnt=0.
- gnt_valid stays 1.
- data_out is unchanged.
REQ-016 If release=1 and the grantee's request is still high, the grantee SHALL still be excluded from the re-arbitration when other requests are pending.
REQ-017 With MAX_HOLD=1, each grant SHALL last exactly one cycle, giving one-cycle rotation among all requesters.
REQ-018 Requests that rise or fall while another grant is active SHALL affect only the next arbitration and SHALL never change data_out mid-grant.
REQ-019 All outputs SHALL be driven from registers; no combinational path from datain or release to any output.

Reset
REQ-020 While rst=1, the block SHALL force the following, asynchronously:
- state=IDLE;
- gnt_valid=0;
- data_out=2'b00;
- hold_cnt=0;
- last=3, so that requester 0 has first priority after reset.
REQ-021 Assertion of rst during GRANT SHALL drop gnt_valid immediately, without waiting for a clock edge.
REQ-022 The first arbitration after rst deasserts SHALL occur on the first rising edge with rst=0.

Verification
REQ-023 The bench SHALL cover the following directed scenarios with MAX_HOLD=4:
- Reset, then datain=4'b1111 held, release=0 -> data_out sequence 0,1,2,3,0 with 4 cycles each; gnt_valid=1 continuously after the first grant.
- datain=4'b0100 only, held 10 cycles -> data_out=2; gnt_valid=1 throughout; hold_cnt counts 0,1,2,3,0,1,...
- Grant active on 1 with datain=4'b1010; pulse release for 1 cycle at hold_cnt=1 -> next cycle data_out=3, hold_cnt=0.
- Grant on 0, datain drops to 4'b0000 -> next cycle gnt_valid=0 and data_out stays 0; then datain=4'b0001 -> grant to 0 one cycle later.
- rst asserted mid-grant at a non-edge time -> gnt_valid=0 immediately; after release of rst with datain=4'b1000 -> data_out=3 one cycle later.
- MAX_HOLD=1 with datain=4'b0110 -> data_out alternates 1,2,1,2 every cycle.

Source files
------------

// File: rtl/rr_encoder_4t2.sv
// Round-robin arbiter over four requesters with a bounded grant hold time.
// Outputs are registered: granted index, its valid flag and the cycles held so far.
module rr_encoder_4t2 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] datain,
    // "release" is a reserved word, so the grantee-finished input is gnt_release
    input  logic       gnt_release,
    output logic       gnt_valid,
    output logic [1:0] data_out,
    output logic [2:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] last;

    logic [3:0] owner_mask;
    logic [3:0] eligible;
    logic [3:0] arb_req;
    logic [1:0] arb_base;
    logic [1:0] idx;
    logic [1:0] pick;
    logic       pick_found;
    logic       grant_end;

    always_comb begin
        owner_mask = 4'b0001 << data_out;
        grant_end  = gnt_release || !datain[data_out] ||
                     (hold_cnt == 3'(MAX_HOLD - 1));
        // The ending grantee stays eligible only when nobody else is asking
        eligible   = (datain == owner_mask) ? datain : (datain & ~owner_mask);

        if (state == GRANT) begin
            arb_req  = eligible;
            arb_base = data_out;
        end else begin
            arb_req  = datain;
            arb_base = last;
        end

        idx        = '0;
        pick       = arb_base;
        pick_found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = arb_base + 2'(i);
            if (!pick_found && arb_req[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            data_out  <= '0;
            hold_cnt  <= '0;
            last      <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (datain != '0) begin
                        state     <= GRANT;
                        gnt_valid <= 1'b1;
                        data_out  <= pick;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        last     <= data_out;
                        hold_cnt <= '0;
                        if (pick_found) begin
                            data_out <= pick;
                        end else begin
                            state     <= IDLE;
                            gnt_valid <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 3'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_encoder_4t2.sv
// Directed bench for rr_encoder_4t2: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_rr_encoder_4t2;

    logic       clk;
    logic       rst;
    logic [3:0] datain;
    logic       rel;
    logic       v4, v1;
    logic [1:0] o4, o1;
    logic [2:0] c4, c1;

    typedef struct {
        logic       v;
        logic [1:0] o;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    rr_encoder_4t2 #(.MAX_HOLD(4)) u4 (
        .clk(clk), .rst(rst), .datain(datain), .gnt_release(rel),
        .gnt_valid(v4), .data_out(o4), .hold_cnt(c4)
    );

    rr_encoder_4t2 #(.MAX_HOLD(1)) u1 (
        .clk(clk), .rst(rst), .datain(datain), .gnt_release(rel),
        .gnt_valid(v1), .data_out(o1), .hold_cnt(c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input int sel, input string tag, input exp_t e);
        if (sel == 0) begin
            check({tag, ".gnt_valid"}, {7'b0, v4}, {7'b0, e.v});
            check({tag, ".data_out"},  {6'b0, o4}, {6'b0, e.o});
            check({tag, ".hold_cnt"},  {5'b0, c4}, {5'b0, e.c});
        end else begin
            check({tag, ".gnt_valid"}, {7'b0, v1}, {7'b0, e.v});
            check({tag, ".data_out"},  {6'b0, o1}, {6'b0, e.o});
            check({tag, ".hold_cnt"},  {5'b0, c1}, {5'b0, e.c});
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input int sel, input string tag, input logic [3:0] din,
                        input logic rl, input logic ev, input logic [1:0] eo,
                        input logic [2:0] ec);
        exp_t e;
        datain = din;
        rel    = rl;
        sb.push_back('{v: ev, o: eo, c: ec});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_out(sel, tag, e);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst    = 1'b1;
        datain = 4'b0000;
        rel    = 1'b0;

        #2;
        check_out(0, "reset_async", '{v: 1'b0, o: 2'd0, c: 3'd0});
        @(posedge clk);
        #1;
        check_out(0, "reset_edge", '{v: 1'b0, o: 2'd0, c: 3'd0});
        rst = 1'b0;

        // All four requesting: 0,1,2,3,0 with four cycles each
        for (int k = 0; k < 20; k++)
            step(0, $sformatf("s1[%0d]", k), 4'b1111, 1'b0, 1'b1,
                 2'((k / 4) % 4), 3'(k % 4));

        // Sole requester 2 is re-granted every time its hold expires
        for (int k = 0; k < 10; k++)
            step(0, $sformatf("s2[%0d]", k), 4'b0100, 1'b0, 1'b1, 2'd2, 3'(k % 4));

        // Release pulse while granted to 1 with 3 also pending
        step(0, "s3_to1",   4'b0010, 1'b0, 1'b1, 2'd1, 3'd0);
        step(0, "s3_hold",  4'b1010, 1'b0, 1'b1, 2'd1, 3'd1);
        step(0, "s3_rel",   4'b1010, 1'b1, 1'b1, 2'd3, 3'd0);

        // Requests vanish: idle with data_out kept, then re-grant 0
        step(0, "s4_to0",   4'b0001, 1'b0, 1'b1, 2'd0, 3'd0);
        step(0, "s4_drop",  4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
        step(0, "s4_idle",  4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
        step(0, "s4_regnt", 4'b0001, 1'b0, 1'b1, 2'd0, 3'd0);

        // Asynchronous reset in the middle of a grant to 3
        step(0, "s5_to3",   4'b1000, 1'b0, 1'b1, 2'd3, 3'd0);
        #3;
        rst = 1'b1;
        #1;
        check_out(0, "s5_rst_now", '{v: 1'b0, o: 2'd0, c: 3'd0});
        @(posedge clk);
        #1;
        check_out(0, "s5_rst_hold", '{v: 1'b0, o: 2'd0, c: 3'd0});
        rst = 1'b0;
        step(0, "s5_after", 4'b1000, 1'b0, 1'b1, 2'd3, 3'd0);

        // MAX_HOLD=1 instance: one-cycle rotation between 1 and 2
        for (int k = 0; k < 6; k++)
            step(1, $sformatf("s6[%0d]", k), 4'b0110, 1'b0, 1'b1,
                 (k % 2 == 0) ? 2'd1 : 2'd2, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
